// File: rtl/lut_layer_pipe.sv
// lut_layer_pipe: one layer of LUT neurons behind a valid/ready pipeline.
// Each neuron owns a 2^IN_BITS x OUT_BITS distributed-RAM table that is
// loaded through the cfg_* write port and read once per vector.
// Ports:
//   clk, rst (async, active-low)
//   in_data/in_valid/in_ready     : neuron k address at [k*IN_BITS +: IN_BITS]
//   out_data/out_valid/out_ready  : neuron k result at [k*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_neuron/cfg_addr/cfg_data : table write port
// OUT_REG=1 gives a 2-stage pipe (address register, then result register).
// OUT_REG=0 looks up on acceptance and registers the result (1 stage).

module lut_layer_pipe #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 2,
    parameter int OUT_REG   = 1,
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int AW = N_NEURONS * IN_BITS,
    localparam int DW = N_NEURONS * OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                cfg_we,
    input  logic [NW-1:0]       cfg_neuron,
    input  logic [IN_BITS-1:0]  cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data
);

    // Held low through reset and the first edge after it, so in_ready
    // only rises on the first clock edge after release.
    logic          rdy_en_q;

    logic          v1_q, v1_d;
    logic [AW-1:0] a1_q, a1_d;
    logic          v2_q, v2_d;
    logic [DW-1:0] d2_q, d2_d;

    logic          adv;
    logic          accept;
    logic [AW-1:0] la;
    logic [DW-1:0] lk;

    // The whole pipe moves together whenever the output slot can drain.
    assign adv      = !v2_q || out_ready;
    assign in_ready = rdy_en_q && adv && !cfg_we;
    assign accept   = in_valid && in_ready;

    // Lookup address: stage-1 register in the 2-stage pipe, else the input.
    assign la = (OUT_REG != 0) ? a1_q : in_data;

    assign out_valid = v2_q;
    assign out_data  = d2_q;

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_nrn
        localparam logic [NW:0] KID = (NW+1)'(k);

        logic [OUT_BITS-1:0] tbl_q [2**IN_BITS];
        logic                we_k;

        // Out-of-range neuron indices match no table and are dropped.
        assign we_k = cfg_we && ({1'b0, cfg_neuron} == KID);

        // Tables are never reset so contents survive a pipeline reset.
        always_ff @(posedge clk) begin
            if (we_k) begin
                tbl_q[cfg_addr] <= cfg_data;
            end
        end

        // Asynchronous read: a same-edge write is seen from the next edge.
        assign lk[k*OUT_BITS +: OUT_BITS] =
            tbl_q[la[k*IN_BITS +: IN_BITS]];
    end

    always_comb begin
        v1_d = v1_q;
        a1_d = a1_q;
        v2_d = v2_q;
        d2_d = d2_q;
        if (adv) begin
            if (OUT_REG != 0) begin
                v1_d = accept;
                if (accept) begin
                    a1_d = in_data;
                end
                v2_d = v1_q;
                if (v1_q) begin
                    d2_d = lk;
                end
            end else begin
                v2_d = accept;
                if (accept) begin
                    d2_d = lk;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
            v1_q     <= 1'b0;
            a1_q     <= '0;
            v2_q     <= 1'b0;
            d2_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            v1_q     <= v1_d;
            a1_q     <= a1_d;
            v2_q     <= v2_d;
            d2_q     <= d2_d;
        end
    end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// tb_lut_layer_pipe: table vectors, scoreboard streaming, backpressure,
// config collisions/stalls and reset for lut_layer_pipe.

module tb_lut_layer_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_neuron;
    logic [7:0]  cfg_addr;
    logic [1:0]  cfg_data;

    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    logic [31:0] in_data1;
    logic        in_valid1, in_ready1;
    logic [7:0]  out_data1;
    logic        out_valid1, out_ready1;

    logic [23:0] in_data2;
    logic        in_valid2, in_ready2;
    logic [5:0]  out_data2;
    logic        out_valid2, out_ready2;
    logic        cfg2_we;
    logic [1:0]  cfg2_neuron;
    logic [7:0]  cfg2_addr;
    logic [1:0]  cfg2_data;

    lut_layer_pipe #(.N_NEURONS(4), .IN_BITS(8), .OUT_BITS(2), .OUT_REG(1)) u0 (
        .clk(clk), .rst(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    lut_layer_pipe #(.N_NEURONS(4), .IN_BITS(8), .OUT_BITS(2), .OUT_REG(0)) u1 (
        .clk(clk), .rst(rst_n),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    lut_layer_pipe #(.N_NEURONS(3), .IN_BITS(8), .OUT_BITS(2), .OUT_REG(1)) u2 (
        .clk(clk), .rst(rst_n),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .cfg_we(cfg2_we), .cfg_neuron(cfg2_neuron),
        .cfg_addr(cfg2_addr), .cfg_data(cfg2_data)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [1:0] mdl [4][256];
    logic [7:0] sbq[$];
    int         pop_cyc[$];
    bit         mon_on = 0;
    bit         stall_q = 0;
    logic [7:0] held;
    bit         bp_done;

    typedef struct {
        logic [31:0] din;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs [8];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] mdl_out(input logic [31:0] d);
        logic [7:0] r;
        for (int k = 0; k < 4; k++) r[k*2 +: 2] = mdl[k][d[k*8 +: 8]];
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each output transfer and
    // checks that a stalled output holds its value.
    always @(negedge clk) begin
        if (!mon_on) begin
            stall_q = 0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) chk("sb_data", out_data, sbq.pop_front());
                pop_cyc.push_back(cyc);
            end
            stall_q = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] e);
        bit ok = 0;
        in_valid = 1;
        in_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept", ok, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) ok = 1;
        end
        @(posedge clk);
        #1;
        if (!ok) chk("drain", ok, 1);
    endtask

    task automatic wr(input int n, input int a, input logic [1:0] d);
        cfg_we = 1;
        cfg_neuron = n[1:0];
        cfg_addr = a[7:0];
        cfg_data = d;
        @(posedge clk);
        #1;
        if (n < 4) mdl[n][a] = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int gap;
        logic [31:0] rv;

        vecs[0] = '{32'h3D3E3F00, 8'h54};
        vecs[1] = '{32'h00000000, 8'h00};
        vecs[2] = '{32'h3F3F3F3F, 8'h55};
        vecs[3] = '{32'hFDBE7F3C, 8'h54};
        vecs[4] = '{32'h3C3D3E3F, 8'h15};
        vecs[5] = '{32'h40C1FF7E, 8'h05};
        vecs[6] = '{32'h123D5678, 8'h10};
        vecs[7] = '{32'hBDFE00C0, 8'h50};

        rst_n = 0;
        cfg_we = 0; cfg_neuron = 0; cfg_addr = 0; cfg_data = 0;
        in_data = 0; in_valid = 0; out_ready = 1;
        in_data1 = 0; in_valid1 = 0; out_ready1 = 1;
        in_data2 = 0; in_valid2 = 0; out_ready2 = 1;
        cfg2_we = 0; cfg2_neuron = 0; cfg2_addr = 0; cfg2_data = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid1", out_valid1, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1);

        // default table: entries with addr[5:0] >= 3D read 01
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 256; a++)
                wr(n, a, (a[5:0] >= 6'h3D) ? 2'b01 : 2'b00);
        cfg_we = 0;

        // N_NEURONS=3 instance: neuron index 3 is out of range
        for (int n = 0; n < 4; n++) begin
            cfg2_we = 1;
            cfg2_neuron = n[1:0];
            cfg2_addr = 8'h11;
            cfg2_data = (n < 3) ? 2'b10 : 2'b01;
            @(posedge clk);
            #1;
        end
        cfg2_we = 0;
        in_valid2 = 1;
        in_data2 = 24'h111111;
        @(negedge clk);
        chk("u2_in_ready", in_ready2, 1);
        @(posedge clk);
        #1;
        in_valid2 = 0;
        @(posedge clk);
        #1;
        chk("u2_out_valid", out_valid2, 1);
        chk("u2_oob_write", out_data2, 6'b101010);

        // one-stage variant: 1-cycle latency
        in_valid1 = 1;
        in_data1 = 32'h3D3E3F00;
        @(negedge clk);
        chk("u1_in_ready", in_ready1, 1);
        @(posedge clk);
        #1;
        in_valid1 = 0;
        chk("u1_lat1_valid", out_valid1, 1);
        chk("u1_lat1_data", out_data1, 8'h54);

        // two-stage: 2-cycle latency
        mon_on = 1;
        in_valid = 1;
        in_data = 32'h3D3E3F00;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        if (in_ready) sbq.push_back(8'h54);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("lat_e1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_data", out_data, 8'h54);
        drain();

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din, vecs[i].exp);
            in_valid = 0;
            drain();
        end

        // write on the same edge as the stage 1->2 lookup
        send(32'h0000003D, 8'h01);
        in_valid = 0;
        cfg_we = 1;
        cfg_neuron = 0;
        cfg_addr = 8'h3D;
        cfg_data = 2'b11;
        @(posedge clk);
        #1;
        cfg_we = 0;
        mdl[0][8'h3D] = 2'b11;
        send(32'h0000003D, 8'h03);
        in_valid = 0;
        drain();
        wr(0, 8'h3D, 2'b01);
        cfg_we = 0;

        // random tables
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 256; a++)
                wr(n, a, 2'($urandom_range(0, 3)));
        cfg_we = 0;

        // streaming
        p0 = pop_cyc.size();
        for (int i = 0; i < 100; i++) begin
            rv = $urandom;
            send(rv, mdl_out(rv));
        end
        in_valid = 0;
        drain();
        chk("stream_count", pop_cyc.size() - p0, 100);
        gap = (pop_cyc.size() >= p0 + 100) ?
              pop_cyc[p0+99] - pop_cyc[p0] : -1;
        chk("stream_gap", gap, 99);

        // random backpressure
        p0 = pop_cyc.size();
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    rv = $urandom;
                    send(rv, mdl_out(rv));
                end
                in_valid = 0;
                bp_done = 1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        drain();
        chk("bp_count", pop_cyc.size() - p0, 100);

        // cfg_we held 3 cycles mid-stream
        p0 = pop_cyc.size();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    rv = $urandom;
                    send(rv, mdl_out(rv));
                end
                in_valid = 0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                cfg_we = 1;
                cfg_neuron = 1;
                cfg_addr = 0;
                cfg_data = mdl[1][0];
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("cfg_stall", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                cfg_we = 0;
            end
        join
        drain();
        chk("cfg_count", pop_cyc.size() - p0, 20);

        // reset with two vectors in flight
        out_ready = 0;
        rv = $urandom;
        send(rv, mdl_out(rv));
        rv = $urandom;
        send(rv, mdl_out(rv));
        in_valid = 0;
        chk("inflight_valid", out_valid, 1);
        mon_on = 0;
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 0);
        sbq.delete();
        out_ready = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rel2_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_out", out_valid, 0);
        end
        @(posedge clk);
        #1;
        mon_on = 1;
        p0 = pop_cyc.size();
        for (int i = 0; i < 5; i++) begin
            rv = $urandom;
            send(rv, mdl_out(rv));
        end
        in_valid = 0;
        drain();
        chk("post_rst_count", pop_cyc.size() - p0, 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
